// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder.
//   op_e        : operation select carried with each beat (add / subtract)
//   slice_width : bits handled by each pipeline slice
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Handshake/data bundle for the pipelined adder.
//   in_valid/in_ready   : operand beat handshake (a, b, carry_in, sub)
//   out_valid/out_ready : result beat handshake (sum, carry_out, overflow)
// master = operand producer / result consumer, slave = the adder.
interface pipelined_adder_if #(
   parameter int WIDTH = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );

endinterface

// File: rtl/adder_slice.sv
// One registered ripple-carry slice of the pipelined adder.
//   clk, rstn : clock, async active-low reset
//   en        : advance enable (low while the pipeline is stalled)
//   a, b_eff  : operand bits for this slice (b already inverted for subtract)
//   cin       : carry into the slice
//   s, cout   : registered slice sum and carry out of the top bit
//   cmsb_in   : registered carry into the top bit (overflow detection)
module adder_slice #(
   parameter int C = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic [C-1:0] a,
   input  logic [C-1:0] b_eff,
   input  logic         cin,
   output logic [C-1:0] s,
   output logic         cout,
   output logic         cmsb_in
);

   logic [C-1:0] s_n;
   logic         c_n;
   logic         cm_n;
   logic         carry;

   always_comb begin
      s_n   = '0;
      carry = cin;
      cm_n  = cin;
      for (int i = 0; i < C; i++) begin
         if (i == C - 1) cm_n = carry;
         s_n[i] = a[i] ^ b_eff[i] ^ carry;
         carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
      end
      c_n = carry;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s       <= '0;
         cout    <= 1'b0;
         cmsb_in <= 1'b0;
      end else if (en) begin
         s       <= s_n;
         cout    <= c_n;
         cmsb_in <= cm_n;
      end
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry/borrow-in, split into STAGES
// carry-chained slices of WIDTH/STAGES bits each.
//   clk, rstn : clock, async active-low reset
//   bus       : slave side of pipelined_adder_if (operand and result handshakes)
// Slice k sees its operand bits k cycles late (input skew) so that the
// carry registered by slice k-1 belongs to the same beat; its result is
// then held STAGES-1-k cycles (output deskew) so a beat's bits line up.
// Any stall freezes every register in the pipe at once.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   pipelined_adder_if.slave bus
);

   localparam int C = slice_width(WIDTH, STAGES);

   if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > WIDTH) begin : g_param_check
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic              en;
   op_e               op;
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;
   logic [WIDTH-1:0]  s_w;
   logic [WIDTH-1:0]  sum_w;
   logic [STAGES-1:0] cout_w;
   logic [STAGES-1:0] cmsb_w;
   logic [STAGES-1:0] vld;
   logic              unused_cmsb;

   assign en           = !(bus.out_valid && !bus.out_ready);
   assign bus.in_ready = en;

   // Subtract is a + ~b + !borrow_in; the inversion rides with the beat.
   assign op      = op_e'(bus.sub);
   assign b_eff   = (op == OP_SUB) ? ~bus.b : bus.b;
   assign cin_eff = (op == OP_SUB) ? !bus.carry_in : bus.carry_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      localparam int D = STAGES - 1 - k;

      logic [C-1:0] a_k;
      logic [C-1:0] b_k;
      logic         cin_k;

      if (k == 0) begin : g_head
         assign a_k   = bus.a[C-1:0];
         assign b_k   = b_eff[C-1:0];
         assign cin_k = cin_eff;
      end else begin : g_skew
         logic [C-1:0] a_dly [k];
         logic [C-1:0] b_dly [k];

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < k; i++) begin
                  a_dly[i] <= '0;
                  b_dly[i] <= '0;
               end
            end else if (en) begin
               a_dly[0] <= bus.a[k*C +: C];
               b_dly[0] <= b_eff[k*C +: C];
               for (int i = 1; i < k; i++) begin
                  a_dly[i] <= a_dly[i-1];
                  b_dly[i] <= b_dly[i-1];
               end
            end
         end

         assign a_k   = a_dly[k-1];
         assign b_k   = b_dly[k-1];
         assign cin_k = cout_w[k-1];
      end

      adder_slice #(.C(C)) u_slice (
         .clk     (clk),
         .rstn    (rstn),
         .en      (en),
         .a       (a_k),
         .b_eff   (b_k),
         .cin     (cin_k),
         .s       (s_w[k*C +: C]),
         .cout    (cout_w[k]),
         .cmsb_in (cmsb_w[k])
      );

      if (D == 0) begin : g_tail
         assign sum_w[k*C +: C] = s_w[k*C +: C];
      end else begin : g_deskew
         logic [C-1:0] s_dly [D];

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < D; i++) s_dly[i] <= '0;
            end else if (en) begin
               s_dly[0] <= s_w[k*C +: C];
               for (int i = 1; i < D; i++) s_dly[i] <= s_dly[i-1];
            end
         end

         assign sum_w[k*C +: C] = s_dly[D-1];
      end
   end

   // Valid bit per stage; bubbles travel like beats and are not squeezed out.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld <= '0;
      end else if (en) begin
         vld[0] <= bus.in_valid;
         for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
      end
   end

   // Only the top slice's carry-into-MSB matters for overflow.
   assign unused_cmsb = ^cmsb_w;

   assign bus.out_valid = vld[STAGES-1];
   assign bus.sum       = sum_w;
   assign bus.carry_out = cout_w[STAGES-1];
   assign bus.overflow  = cout_w[STAGES-1] ^ cmsb_w[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   typedef struct packed {
      logic        ov;
      logic        ir;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } obs_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic rstn8;
   logic rstn16;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(8))  bus8 ();
   pipelined_adder_if #(.WIDTH(16)) bus16 ();

   pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk  (clk),
      .rstn (rstn8),
      .bus  (bus8.slave)
   );

   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
      .clk  (clk),
      .rstn (rstn16),
      .bus  (bus16.slave)
   );

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t ref_model(input int w, input logic [15:0] a, b,
                                      input logic cin, sub);
      exp_t   e;
      longint m, ua, ub, c, sa, sb, r, sr;
      m  = longint'(1) << w;
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      c  = longint'(cin);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (!sub) begin
         r      = ua + ub + c;
         e.cout = (r >= m);
         sr     = sa + sb + c;
      end else begin
         r      = ua - ub - c;
         e.cout = (ua >= ub + c);
         sr     = sa - sb - c;
      end
      e.sum = 16'(r & (m - 1));
      e.ovf = (sr < -(m / 2)) || (sr >= m / 2);
      return e;
   endfunction

   task automatic drive(input bit w, input logic v, input logic [15:0] a, b,
                        input logic cin, sub, ordy);
      if (!w) begin
         bus8.in_valid  = v;
         bus8.a         = a[7:0];
         bus8.b         = b[7:0];
         bus8.carry_in  = cin;
         bus8.sub       = sub;
         bus8.out_ready = ordy;
      end else begin
         bus16.in_valid  = v;
         bus16.a         = a;
         bus16.b         = b;
         bus16.carry_in  = cin;
         bus16.sub       = sub;
         bus16.out_ready = ordy;
      end
   endtask

   function automatic obs_t sample(input bit w);
      obs_t o;
      if (!w) begin
         o.ov   = bus8.out_valid;
         o.ir   = bus8.in_ready;
         o.sum  = {8'h00, bus8.sum};
         o.cout = bus8.carry_out;
         o.ovf  = bus8.overflow;
      end else begin
         o.ov   = bus16.out_valid;
         o.ir   = bus16.in_ready;
         o.sum  = bus16.sum;
         o.cout = bus16.carry_out;
         o.ovf  = bus16.overflow;
      end
      return o;
   endfunction

   task automatic single_beat(input bit w, input logic [15:0] a, b, input logic cin, sub,
                              input exp_t e, input string name);
      obs_t o;
      int   lat;
      bit   found;
      int   s;
      s = w ? 4 : 2;
      @(negedge clk);
      drive(w, 1'b1, a, b, cin, sub, 1'b1);
      #1 o = sample(w);
      checks++;
      if (o.ir !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: in_ready=%b want 1", name, o.ir);
      end
      @(negedge clk);
      drive(w, 1'b0, a, b, cin, sub, 1'b1);
      lat   = 1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         #1 o = sample(w);
         if (o.ov === 1'b1) found = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s timeout: out_valid never rose, want latency %0d", name, s);
      end else begin
         if (lat != s) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, s);
         end
         checks++;
         if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
         end
      end
   endtask

   task automatic test_reset();
      obs_t o;
      repeat (2) @(negedge clk);
      #1 o = sample(0);
      checks++;
      if (o.ov !== 1'b0 || o.ir !== 1'b1) begin
         errors++;
         $display("FAIL reset8 handshake: out_valid=%b in_ready=%b want 0 1", o.ov, o.ir);
      end
      checks++;
      if (o.sum !== 16'h0 || o.cout !== 1'b0 || o.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset8 data: sum=%h cout=%b ovf=%b want 0 0 0", o.sum, o.cout, o.ovf);
      end
      o = sample(1);
      checks++;
      if (o.ov !== 1'b0 || o.ir !== 1'b1 || o.sum !== 16'h0) begin
         errors++;
         $display("FAIL reset16: out_valid=%b in_ready=%b sum=%h want 0 1 0", o.ov, o.ir, o.sum);
      end
      @(posedge clk);
      #2;
      rstn8  = 1'b1;
      rstn16 = 1'b1;
   endtask

   task automatic test_directed();
      vec_t tbl[7];
      tbl = '{
         '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}},
         '{16'h007F, 16'h0001, 1'b0, 1'b0, '{16'h0080, 1'b0, 1'b1}},
         '{16'h0001, 16'h0001, 1'b1, 1'b0, '{16'h0003, 1'b0, 1'b0}},
         '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'h00FE, 1'b0, 1'b0}},
         '{16'h0080, 16'h0001, 1'b0, 1'b1, '{16'h007F, 1'b1, 1'b1}},
         '{16'h0010, 16'h0005, 1'b1, 1'b1, '{16'h000A, 1'b1, 1'b0}},
         '{16'h0080, 16'h0080, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}}
      };
      for (int i = 0; i < 7; i++)
         single_beat(0, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e,
                     $sformatf("directed%0d", i));
   endtask

   task automatic test_back_to_back();
      logic [15:0] va[4], vb[4];
      logic        vc[4], vs[4];
      exp_t        e;
      obs_t        o;
      logic        exp_ov;
      for (int i = 0; i < 4; i++) begin
         va[i] = 16'($urandom);
         vb[i] = 16'($urandom);
         vc[i] = 1'($urandom);
         vs[i] = 1'($urandom);
      end
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (cyc < 4) drive(0, 1'b1, va[cyc], vb[cyc], vc[cyc], vs[cyc], 1'b1);
         else         drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
         #1 o = sample(0);
         exp_ov = (cyc >= 2 && cyc <= 5);
         checks++;
         if (o.ov !== exp_ov) begin
            errors++;
            $display("FAIL b2b valid cycle %0d: out_valid=%b want %b", cyc, o.ov, exp_ov);
         end
         if (exp_ov && o.ov === 1'b1) begin
            e = ref_model(8, va[cyc-2], vb[cyc-2], vc[cyc-2], vs[cyc-2]);
            checks++;
            if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
               errors++;
               $display("FAIL b2b beat %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                        cyc - 2, o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] va[6], vb[6];
      logic        vc[6], vs[6];
      exp_t        q[$];
      exp_t        e;
      obs_t        o, held;
      int          idx, got;
      logic        rr;
      idx  = 0;
      got  = 0;
      held = '0;
      for (int i = 0; i < 6; i++) begin
         va[i] = 16'($urandom);
         vb[i] = 16'($urandom);
         vc[i] = 1'($urandom);
         vs[i] = 1'($urandom);
      end
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         rr = !(cyc >= 3 && cyc <= 5);
         if (idx < 6) drive(0, 1'b1, va[idx], vb[idx], vc[idx], vs[idx], rr);
         else         drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, rr);
         #1 o = sample(0);
         checks++;
         if (o.ir !== rr) begin
            errors++;
            $display("FAIL stall in_ready cycle %0d: got %b want %b", cyc, o.ir, rr);
         end
         if (cyc == 3) held = o;
         if (cyc == 4 || cyc == 5) begin
            checks++;
            if (o.ov !== 1'b1 || {o.sum, o.cout, o.ovf} !== {held.sum, held.cout, held.ovf}) begin
               errors++;
               $display("FAIL stall hold cycle %0d: got v=%b sum=%h want v=1 sum=%h",
                        cyc, o.ov, o.sum, held.sum);
            end
         end
         if (o.ov === 1'b1 && rr) begin
            got++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL stall extra beat: sum=%h with none expected", o.sum);
            end else begin
               e = q.pop_front();
               if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
                  errors++;
                  $display("FAIL stall beat %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           got - 1, o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
               end
            end
         end
         if (idx < 6 && o.ir === 1'b1) begin
            q.push_back(ref_model(8, va[idx], vb[idx], vc[idx], vs[idx]));
            idx++;
         end
      end
      checks++;
      if (got != 6 || q.size() != 0) begin
         errors++;
         $display("FAIL stall count: got %0d beats (%0d pending) want 6", got, q.size());
      end
   endtask

   task automatic test_random(input bit w, input int n);
      exp_t        q[$];
      exp_t        e;
      obs_t        o, prev;
      logic [15:0] ra, rb;
      logic        rc, rs, rv, rr;
      bit          prev_stall;
      int          acc, got, wd;
      wd = w ? 16 : 8;
      acc = 0;
      got = 0;
      prev_stall = 0;
      prev = '0;
      for (int cyc = 0; cyc < n + 16; cyc++) begin
         @(negedge clk);
         rv = (cyc < n) ? ($urandom_range(0, 3) != 0) : 1'b0;
         rr = (cyc < n) ? ($urandom_range(0, 3) != 0) : 1'b1;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         drive(w, rv, ra, rb, rc, rs, rr);
         #1 o = sample(w);
         if (prev_stall) begin
            checks++;
            if (o.ov !== 1'b1 || {o.sum, o.cout, o.ovf} !== {prev.sum, prev.cout, prev.ovf}) begin
               errors++;
               $display("FAIL rand%0d hold cycle %0d: got v=%b sum=%h want v=1 sum=%h",
                        wd, cyc, o.ov, o.sum, prev.sum);
            end
         end
         if (o.ov === 1'b1 && rr) begin
            got++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand%0d extra beat: sum=%h with none expected", wd, o.sum);
            end else begin
               e = q.pop_front();
               if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
                  errors++;
                  $display("FAIL rand%0d beat %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           wd, got - 1, o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
               end
            end
         end
         if (rv && o.ir === 1'b1) begin
            q.push_back(ref_model(wd, ra, rb, rc, rs));
            acc++;
         end
         prev_stall = (o.ov === 1'b1) && !rr;
         prev = o;
      end
      checks++;
      if (got != acc || q.size() != 0) begin
         errors++;
         $display("FAIL rand%0d count: got %0d beats want %0d", wd, got, acc);
      end
   endtask

   task automatic test_reset_mid(input bit w);
      obs_t  o;
      string nm;
      nm = w ? "rstmid16" : "rstmid8";
      @(negedge clk);
      drive(w, 1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(w, 1'b1, 16'h00FF, 16'h0101, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      if (w) rstn16 = 1'b0;
      else   rstn8  = 1'b0;
      #1 o = sample(w);
      checks++;
      if (o.ov !== 1'b0 || o.ir !== 1'b1) begin
         errors++;
         $display("FAIL %s async handshake: out_valid=%b in_ready=%b want 0 1", nm, o.ov, o.ir);
      end
      checks++;
      if (o.sum !== 16'h0 || o.cout !== 1'b0 || o.ovf !== 1'b0) begin
         errors++;
         $display("FAIL %s async data: sum=%h cout=%b ovf=%b want 0 0 0", nm, o.sum, o.cout, o.ovf);
      end
      drive(w, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      repeat (3) begin
         @(negedge clk);
         #1 o = sample(w);
         checks++;
         if (o.ov !== 1'b0) begin
            errors++;
            $display("FAIL %s held: out_valid=%b want 0", nm, o.ov);
         end
      end
      @(posedge clk);
      #2;
      if (w) rstn16 = 1'b1;
      else   rstn8  = 1'b1;
      single_beat(w, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, nm);
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         #1 o = sample(w);
         checks++;
         if (o.ov !== 1'b0) begin
            errors++;
            $display("FAIL %s leak cycle %0d: out_valid=%b want 0", nm, cyc, o.ov);
         end
      end
   endtask

   initial begin
      rstn8  = 1'b0;
      rstn16 = 1'b0;
      drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_random(0, 300);
      test_random(1, 200);
      test_reset_mid(0);
      test_reset_mid(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the single-bit `full_adder`. It adds or subtracts two `WIDTH`-bit operands with carry/borrow-in, split into `STAGES` registered carry-chained slices. A valid/ready handshake with full-pipeline stall sits on the input and output. It is the arithmetic building block for the formal-verification suite's datapath blocks and is checked by both simulation and SBY property runs.

## Interface
- `WIDTH`, 8: operand/result width; must be divisible by `STAGES`.
- `STAGES`, 2: pipeline depth, one `WIDTH/STAGES`-bit slice per stage; 1 ≤ `STAGES` ≤ `WIDTH`.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B.
- `carry_in` in 1: carry-in (add) or borrow-in (sub).
- `sub` in 1: 0 = add, 1 = subtract.
- `out_valid` out 1: result beat present.
- `out_ready` in 1: downstream accepts result.
- `sum` out `WIDTH`: result.
- `carry_out` out 1: raw carry out of MSB.
- `overflow` out 1: signed (two's complement) overflow.

## Operation
- Add: `{carry_out,sum} = a + b + carry_in`.
- Sub: `{carry_out,sum} = a + ~b + !carry_in`, i.e. `a - b - carry_in`; `carry_out = 1` means no borrow.
- `overflow` = carry into MSB XOR carry out of MSB, using the effective (possibly inverted) B.
- Slice k (0 = LSB) computes bits `[k*C +: C]`, where `C = WIDTH/STAGES`. It uses the carry registered by slice k−1 in the previous stage; slice 0 uses the effective carry-in.
- Input skew: operand bits of slice k are delayed k cycles before use. Output deskew: slice k result is delayed `STAGES-1-k` cycles, so all `sum` bits of one beat emerge together.
- Per-stage valid bit travels with the data. Bubbles are not collapsed.
- Stall: `stall = out_valid && !out_ready`. On stall, every pipeline/skew register holds and `in_ready = 0`. Otherwise all registers advance and `in_ready = 1`. `in_ready` is combinational from `out_valid`/`out_ready` only, never from `in_valid`.
- A beat entering with `in_valid = 0` propagates as a bubble. Data registers may update freely, but only valid beats are reported.
- `sub` and `carry_in` are sampled with the beat, like `a`/`b`.

## Timing
- Latency: exactly `STAGES` cycles from accepting edge to `out_valid` high, with no stalls. Each stall cycle adds one.
- Throughput: one beat per cycle while `out_ready = 1`.
- Reset (`rstn` low, asynchronous): all valid bits clear. `out_valid = 0`, `sum = 0`, `carry_out = 0`, `overflow = 0`, `in_ready = 1`. Data registers are cleared too, so formal `anyinit` values never leak.
- Reset mid-operation: all in-flight beats are discarded, none is emitted. Acceptance resumes on the first rising edge after `rstn` rises.
- Results hold stable while `out_valid && !out_ready`.
- `STAGES = 1`: a single registered adder with latency 1 and no skew registers.

## Structure
- Package `adder_pkg`: `op_e` enum (`OP_ADD`, `OP_SUB`) and a helper function `slice_width(WIDTH, STAGES)`.
- Sub-module `adder_slice`: a `C`-bit registered ripple slice with enable. Inputs: `a`, `b_eff`, `cin`, `en`. Outputs: `s`, `cout`, `cmsb_in` (carry into the top bit, used by the final slice for `overflow`).
- Top level generates `STAGES` slices plus skew/deskew shift registers. Elaboration asserts `WIDTH % STAGES == 0`.
- Formal properties: result equals the reference arithmetic `STAGES` cycles after acceptance, and no beat is lost or duplicated under stall.

## Test plan
Each case uses `WIDTH = 8`, `STAGES = 2` unless stated.
- Add `a=0xFF, b=0x01, carry_in=0`, `out_ready=1` → after 2 cycles `sum=0x00, carry_out=1, overflow=0`.
- Add `a=0x7F, b=0x01, carry_in=0` → `sum=0x80, carry_out=0, overflow=1`. Add `0x01+0x01+1` → `sum=0x03`.
- Sub `a=0x05, b=0x07, carry_in=0` → `sum=0xFE, carry_out=0, overflow=0`. Sub `0x80-0x01` → `sum=0x7F, overflow=1`.
- Back-to-back 4 beats with `out_ready=1` → 4 consecutive `out_valid` cycles, in order, starting cycle 2.
- Hold `out_ready=0` for 3 cycles while streaming → `in_ready=0` during the stall, outputs stable, no beat lost or duplicated.
- Drop `rstn` with 2 beats in flight → immediately `out_valid=0, sum=0`; after release, the first new beat has latency 2. Repeat with `WIDTH=16, STAGES=4` on `0xFFFF+0x0001` → `0x0000`, `carry_out=1`.
